// File: rtl/cga_vram_sequencer_pkg.sv
// Shared definitions for the CGA VRAM sequencer slice.
//   - Phase numbers of the 16-phase character slot used by the display
//     fetch schedule and the CPU grant windows.
//   - State type of the CPU access port.
package cga_pkg;

  localparam logic [3:0] PH_CHAR = 4'd0;
  localparam logic [3:0] PH_ATT  = 4'd2;
  localparam logic [3:0] PH_ROM  = 4'd4;
  localparam logic [3:0] PH_CPU0 = 4'd6;
  localparam logic [3:0] PH_CPU1 = 4'd10;
  localparam logic [3:0] PH_END  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } cpu_state_t;

endpackage

// File: rtl/cga_vram_sequencer_if.sv
// VRAM / CPU bus bundle of the sequencer.
//   CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata -> sequencer
//              cpu_ack, cpu_rdata                   <- sequencer
//   VRAM side: vram_addr, vram_rd, vram_we, vram_wdata <- sequencer
//              vram_data (1-clock read latency)        -> sequencer
// slave  : sequencer view.
// master : environment view (CPU host + VRAM).
interface cga_vram_sequencer_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic [13:0] vram_addr;
  logic        vram_rd;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_data,
    output cpu_ack, cpu_rdata, vram_addr, vram_rd, vram_we, vram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_data,
    input  cpu_ack, cpu_rdata, vram_addr, vram_rd, vram_we, vram_wdata
  );

endinterface

// File: rtl/cga_vram_sequencer_cpu_port.sv
// CPU access port: one VRAM access per cpu_req level.
//   grant      : this clock is a legal CPU slot on the VRAM
//   acc_rd/we  : CPU read / write strobe for this clock (only while granted)
//   cpu_ack    : one-clock pulse in the clock after the access
//   cpu_rdata  : read data; live during the ack clock, held afterwards
module cga_vram_cpu_port
  import cga_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       grant,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] vram_data,
  output logic       acc_rd,
  output logic       acc_we,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata
);

  cpu_state_t state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    acc_rd    = 1'b0;
    acc_we    = 1'b0;
    cpu_ack   = 1'b0;
    cpu_rdata = rdata_q;
    case (state_q)
      IDLE: if (cpu_req) state_d = WAIT;
      WAIT: begin
        if (grant) begin
          acc_rd  = ~cpu_we;
          acc_we  = cpu_we;
          we_d    = cpu_we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cpu_ack = 1'b1;
        // Read data is forwarded in the ack clock so it is valid with cpu_ack.
        if (!we_q) begin
          rdata_d   = vram_data;
          cpu_rdata = vram_data;
        end
        state_d = DONE;
      end
      DONE:    if (!cpu_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/cga_vram_sequencer.sv
// Character-slot sequencer and VRAM arbiter for the CGA/Tandy video path.
//   clk, reset_n   : pixel clock, async active-low reset
//   hres_mode      : 1 = 16-clock slot, 0 = 32-clock slot (taken at slot wrap)
//   fetch_en       : display fetch enable
//   crtc_addr      : character address from the CRTC
//   clk_seq        : slot position counter
//   hclk, vram_read_char, vram_read_att, charrom_read, disp_pipeline:
//                    one-clock datapath strobes
//   bus            : CPU request port and VRAM port (slave modport)
module cga_vram_sequencer
  import cga_pkg::*;
#(
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hres_mode,
  input  logic        fetch_en,
  input  logic [12:0] crtc_addr,
  output logic [4:0]  clk_seq,
  output logic        hclk,
  output logic        vram_read_char,
  output logic        vram_read_att,
  output logic        charrom_read,
  output logic        disp_pipeline,
  cga_vram_sequencer_if.slave bus
);

  if (FETCH_LAT != 1) begin : g_lat_check
    $error("cga_vram_sequencer: only FETCH_LAT=1 is supported");
  end

  logic [4:0] clk_seq_q, clk_seq_d;
  logic       hres_q, hres_d;
  logic       run_q, run_d;
  logic [3:0] ph;
  logic       first_clk, last_clk, slot_end;
  logic       disp_en, disp_rd, grant;
  logic       acc_rd, acc_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_seq_q <= '0;
      hres_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      clk_seq_q <= clk_seq_d;
      hres_q    <= hres_d;
      run_q     <= run_d;
    end
  end

  // The first clock after reset holds clk_seq at 0 with all display strobes
  // quiet and loads the slot width, so reset really shows every output at 0.
  always_comb begin
    ph        = hres_q ? clk_seq_q[3:0] : clk_seq_q[4:1];
    first_clk = hres_q | ~clk_seq_q[0];
    last_clk  = hres_q |  clk_seq_q[0];
    slot_end  = hres_q ? (clk_seq_q[3:0] == 4'hF) : (clk_seq_q == 5'h1F);
    clk_seq_d = clk_seq_q + 5'd1;
    hres_d    = hres_q;
    run_d     = 1'b1;
    if (!run_q || slot_end) begin
      clk_seq_d = '0;
      hres_d    = hres_mode;
    end
  end

  always_comb begin
    disp_en        = run_q & fetch_en;
    disp_rd        = disp_en & first_clk & ((ph == PH_CHAR) | (ph == PH_ATT));
    vram_read_char = disp_en & last_clk & (ph == PH_CHAR + 4'd1);
    vram_read_att  = disp_en & last_clk & (ph == PH_ATT + 4'd1);
    charrom_read   = run_q & last_clk & (ph == PH_ROM);
    disp_pipeline  = run_q & last_clk & (ph == PH_END);
    hclk           = disp_pipeline;
    // With fetch off the CPU owns the VRAM outright.
    grant          = fetch_en ? (first_clk & ((ph == PH_CPU0) | (ph == PH_CPU1))) : 1'b1;
  end

  cga_vram_cpu_port u_cpu_port (
    .clk       (clk),
    .reset_n   (reset_n),
    .grant     (grant),
    .cpu_req   (bus.cpu_req),
    .cpu_we    (bus.cpu_we),
    .vram_data (bus.vram_data),
    .acc_rd    (acc_rd),
    .acc_we    (acc_we),
    .cpu_ack   (bus.cpu_ack),
    .cpu_rdata (bus.cpu_rdata)
  );

  always_comb begin
    clk_seq        = clk_seq_q;
    bus.vram_rd    = disp_rd | acc_rd;
    bus.vram_we    = acc_we;
    bus.vram_wdata = acc_we ? bus.cpu_wdata : '0;
    if (acc_rd | acc_we) begin
      bus.vram_addr = bus.cpu_addr;
    end else if (disp_en & (ph == PH_CHAR)) begin
      bus.vram_addr = {crtc_addr, 1'b0};
    end else if (disp_en & (ph == PH_ATT)) begin
      bus.vram_addr = {crtc_addr, 1'b1};
    end else begin
      bus.vram_addr = '0;
    end
  end

endmodule

// File: tb/tb_cga_vram_sequencer.sv
module tb_cga_vram_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        hres_mode = 1'b1;
  logic        fetch_en = 1'b1;
  logic [12:0] crtc_addr = 13'h123;
  logic [4:0]  clk_seq;
  logic        hclk, vram_read_char, vram_read_att, charrom_read, disp_pipeline;

  cga_vram_sequencer_if bus_if ();

  cga_vram_sequencer #(.FETCH_LAT(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hres_mode      (hres_mode),
    .fetch_en       (fetch_en),
    .crtc_addr      (crtc_addr),
    .clk_seq        (clk_seq),
    .hclk           (hclk),
    .vram_read_char (vram_read_char),
    .vram_read_att  (vram_read_att),
    .charrom_read   (charrom_read),
    .disp_pipeline  (disp_pipeline),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  function automatic logic [7:0] init_byte(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  // VRAM environment: write on the strobe edge, read data valid the next clock.
  logic [7:0] vram [16384];
  always @(posedge clk) begin
    if (bus_if.vram_we) vram[bus_if.vram_addr] <= bus_if.vram_wdata;
    if (bus_if.vram_rd) bus_if.vram_data <= vram[bus_if.vram_addr];
  end

  // Reference model state: slot position, slot width, CPU request progress.
  logic [7:0]  m_mem [16384];
  logic [4:0]  m_seq = '0;
  logic        m_hres = 1'b0, m_run = 1'b0;
  logic        m_pend = 1'b0, m_ack = 1'b0, m_done = 1'b0, m_ack_rd = 1'b0;
  logic [13:0] m_acc_addr = '0;
  logic [7:0]  m_rdata = '0;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      vram[i]  = init_byte(14'(i));
      m_mem[i] = init_byte(14'(i));
    end
  end

  function automatic bit m_grant(input int seq, input bit hres, input bit fe);
    int p;
    bit first;
    p     = hres ? seq : seq / 2;
    first = hres || (seq % 2 == 0);
    return !fe || (first && (p == 6 || p == 10));
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit cpu_now;
    if (!reset_n) begin
      m_seq = '0; m_hres = 1'b0; m_run = 1'b0;
      m_pend = 1'b0; m_ack = 1'b0; m_done = 1'b0; m_ack_rd = 1'b0;
      m_acc_addr = '0; m_rdata = '0;
    end else begin
      cpu_now = m_pend && m_grant(int'(m_seq), m_hres, fetch_en);
      if (m_ack) begin
        m_ack  = 1'b0;
        m_done = 1'b1;
        if (m_ack_rd) m_rdata = m_mem[m_acc_addr];
      end else if (m_done) begin
        if (!bus_if.cpu_req) m_done = 1'b0;
      end else if (m_pend) begin
        if (cpu_now) begin
          m_pend     = 1'b0;
          m_ack      = 1'b1;
          m_ack_rd   = !bus_if.cpu_we;
          m_acc_addr = bus_if.cpu_addr;
          if (bus_if.cpu_we) m_mem[bus_if.cpu_addr] = bus_if.cpu_wdata;
        end
      end else if (bus_if.cpu_req) begin
        m_pend = 1'b1;
      end
      if (!m_run) begin
        m_run = 1'b1; m_seq = '0; m_hres = hres_mode;
      end else if (int'(m_seq) == (m_hres ? 15 : 31)) begin
        m_seq = '0; m_hres = hres_mode;
      end else begin
        m_seq = m_seq + 5'd1;
      end
    end
  end

  always @(negedge clk) begin : compare
    int p;
    bit first, last, de, cpu_now, e_rd, e_we;
    logic [13:0] e_addr;
    logic [7:0]  e_wdata, e_rdata;
    p       = m_hres ? int'(m_seq) : int'(m_seq) / 2;
    first   = m_hres || (m_seq % 2 == 0);
    last    = m_hres || (m_seq % 2 == 1);
    de      = m_run && fetch_en;
    cpu_now = m_pend && m_grant(int'(m_seq), m_hres, fetch_en);
    if (cpu_now)            e_addr = bus_if.cpu_addr;
    else if (de && p == 0)  e_addr = {crtc_addr, 1'b0};
    else if (de && p == 2)  e_addr = {crtc_addr, 1'b1};
    else                    e_addr = '0;
    e_rd    = (de && first && (p == 0 || p == 2)) || (cpu_now && !bus_if.cpu_we);
    e_we    = cpu_now && bus_if.cpu_we;
    e_wdata = e_we ? bus_if.cpu_wdata : 8'h00;
    e_rdata = (m_ack && m_ack_rd) ? m_mem[m_acc_addr] : m_rdata;
    check("m_clk_seq",    32'(clk_seq), 32'(m_seq));
    check("m_vram_addr",  32'(bus_if.vram_addr), 32'(e_addr));
    check("m_vram_rd",    32'(bus_if.vram_rd), 32'(e_rd));
    check("m_vram_we",    32'(bus_if.vram_we), 32'(e_we));
    check("m_vram_wdata", 32'(bus_if.vram_wdata), 32'(e_wdata));
    check("m_read_char",  32'(vram_read_char), 32'(de && last && p == 1));
    check("m_read_att",   32'(vram_read_att), 32'(de && last && p == 3));
    check("m_charrom",    32'(charrom_read), 32'(m_run && last && p == 4));
    check("m_disp_pipe",  32'(disp_pipeline), 32'(m_run && last && p == 15));
    check("m_hclk",       32'(hclk), 32'(m_run && last && p == 15));
    check("m_cpu_ack",    32'(bus_if.cpu_ack), 32'(m_ack));
    check("m_cpu_rdata",  32'(bus_if.cpu_rdata), 32'(e_rdata));
  end

  int ack_cnt = 0;
  int we_cnt = 0;
  always @(negedge clk) begin
    if (bus_if.cpu_ack) ack_cnt++;
    if (bus_if.vram_we) we_cnt++;
  end

  task automatic wait_seq(input logic [4:0] target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clk_seq != target && n < 80);
    if (clk_seq != target) timeout_fail($sformatf("wait_seq_%0d", target));
  endtask

  task automatic measure_period(input string name, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (clk_seq != 5'd0 && n < 80);
    check(name, 32'(n), 32'(exp));
  endtask

  initial begin : stimulus
    int base, found;
    bus_if.cpu_req   = 1'b0;
    bus_if.cpu_we    = 1'b0;
    bus_if.cpu_addr  = '0;
    bus_if.cpu_wdata = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_seq", 32'(clk_seq), 32'd0);
    check("rst_vram_rd", 32'(bus_if.vram_rd), 32'd0);
    check("rst_vram_addr", 32'(bus_if.vram_addr), 32'd0);
    check("rst_cpu_ack", 32'(bus_if.cpu_ack), 32'd0);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Hi-res display schedule, crtc_addr 0x123.
    wait_seq(5'd0);
    check("h_addr_char", 32'(bus_if.vram_addr), 32'h246);
    check("h_rd_char", 32'(bus_if.vram_rd), 32'd1);
    wait_seq(5'd1);  check("h_read_char", 32'(vram_read_char), 32'd1);
    wait_seq(5'd2);  check("h_addr_att", 32'(bus_if.vram_addr), 32'h247);
    wait_seq(5'd3);  check("h_read_att", 32'(vram_read_att), 32'd1);
    wait_seq(5'd4);  check("h_charrom", 32'(charrom_read), 32'd1);
    wait_seq(5'd15); check("h_hclk", 32'(hclk), 32'd1);
    check("h_disp_pipe", 32'(disp_pipeline), 32'd1);
    measure_period("h_to_zero", 1);
    measure_period("h_period", 16);

    // Mid-slot width change applies only after the current slot ends.
    wait_seq(5'd5);
    #1 hres_mode = 1'b0;
    wait_seq(5'd15);
    @(negedge clk);
    check("toggle_wrap_at_16", 32'(clk_seq), 32'd0);
    @(negedge clk);
    check("l_addr_ph0_2nd", 32'(bus_if.vram_addr), 32'h246);
    check("l_no_char_at1", 32'(vram_read_char), 32'd0);
    wait_seq(5'd3);  check("l_read_char", 32'(vram_read_char), 32'd1);
    wait_seq(5'd7);  check("l_read_att", 32'(vram_read_att), 32'd1);
    wait_seq(5'd9);  check("l_charrom", 32'(charrom_read), 32'd1);
    wait_seq(5'd31); check("l_hclk", 32'(hclk), 32'd1);
    measure_period("l_to_zero", 1);
    measure_period("l_period", 32);

    // CPU read, request raised at ph7 in hi-res: granted at ph10.
    #1 hres_mode = 1'b1;
    wait_seq(5'd31);
    wait_seq(5'd7);
    #1;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 14'h1000;
    base = ack_cnt;
    wait_seq(5'd10);
    check("cpu_rd_strobe", 32'(bus_if.vram_rd), 32'd1);
    check("cpu_rd_addr", 32'(bus_if.vram_addr), 32'h1000);
    @(negedge clk);
    check("cpu_ack_seq", 32'(clk_seq), 32'd11);
    check("cpu_ack", 32'(bus_if.cpu_ack), 32'd1);
    check("cpu_rdata", 32'(bus_if.cpu_rdata), 32'h4A);
    repeat (20) @(negedge clk);
    #1 check("cpu_rd_single_ack", 32'(ack_cnt - base), 32'd1);
    bus_if.cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // CPU write with fetch off, request held long after ack.
    #1;
    fetch_en         = 1'b0;
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = 1'b1;
    bus_if.cpu_addr  = 14'h0010;
    bus_if.cpu_wdata = 8'hA5;
    base = we_cnt;
    @(negedge clk);
    check("wr_we", 32'(bus_if.vram_we), 32'd1);
    check("wr_wdata", 32'(bus_if.vram_wdata), 32'hA5);
    check("wr_addr", 32'(bus_if.vram_addr), 32'h10);
    @(negedge clk);
    check("wr_ack", 32'(bus_if.cpu_ack), 32'd1);
    repeat (6) @(negedge clk);
    #1 check("wr_single_write", 32'(we_cnt - base), 32'd1);
    bus_if.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    bus_if.cpu_req = 1'b1;
    bus_if.cpu_we  = 1'b0;
    @(negedge clk);
    check("rb_rd", 32'(bus_if.vram_rd), 32'd1);
    @(negedge clk);
    check("rb_ack", 32'(bus_if.cpu_ack), 32'd1);
    check("rb_rdata", 32'(bus_if.cpu_rdata), 32'hA5);
    #1 bus_if.cpu_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during ACCESS; held request is served again after release.
    #1;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 14'h0123;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_ack", 32'(bus_if.cpu_ack), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_ack", 32'(bus_if.cpu_ack), 32'd0);
    check("arst_clk_seq", 32'(clk_seq), 32'd0);
    check("arst_vram_rd", 32'(bus_if.vram_rd), 32'd0);
    check("arst_rdata", 32'(bus_if.cpu_rdata), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      @(negedge clk);
      if (bus_if.cpu_ack) found = 1;
    end
    if (found == 0) timeout_fail("reserve_ack");
    else check("reserve_rdata", 32'(bus_if.cpu_rdata), 32'h78);
    #1 bus_if.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
